dct8_serial_fwd: RTL and testbench

DCT8_SERIAL_FWD -- requirements
Module: dct8_serial_fwd

---
 rtl/dct_pkg.sv | 34 +++
 rtl/dct8_coef_rom.sv | 12 +
 rtl/dct8_serial_fwd.sv | 116 +++++++++++
 tb/tb_dct8_serial_fwd.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the 8-point integer DCT blocks: widths, FSM states, coefficient table.
// Row k of DCT8_ROWS holds C[k][0..7], with C[k][0] in the most significant byte.
package dct_pkg;

  localparam int DW    = 25;
  localparam int ACC_W = 37;
  localparam int SH_W  = 4;
  localparam int CW    = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } dct_state_t;

  localparam logic [63:0] DCT8_ROWS [8] = '{
    {8{8'sd64}},
    {8'sd89, 8'sd75, 8'sd50, 8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
    {8'sd83, 8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36, 8'sd36, 8'sd83},
    {8'sd75, -8'sd18, -8'sd89, -8'sd50, 8'sd50, 8'sd89, 8'sd18, -8'sd75},
    {8'sd64, -8'sd64, -8'sd64, 8'sd64, 8'sd64, -8'sd64, -8'sd64, 8'sd64},
    {8'sd50, -8'sd89, 8'sd18, 8'sd75, -8'sd75, -8'sd18, 8'sd89, -8'sd50},
    {8'sd36, -8'sd83, 8'sd83, -8'sd36, -8'sd36, 8'sd83, -8'sd83, 8'sd36},
    {8'sd18, -8'sd50, 8'sd75, -8'sd89, 8'sd89, -8'sd75, 8'sd50, -8'sd18}
  };

  // Byte ~c counted from the LSB is column c counted from the MSB.
  function automatic logic signed [CW-1:0] dct8_coef(input logic [2:0] k, input logic [2:0] c);
    logic [63:0] row;
    row = DCT8_ROWS[k];
    return $signed(row[{~c, 3'b000} +: CW]);
  endfunction

endpackage

// File: rtl/dct8_coef_rom.sv
// Combinational forward-DCT coefficient lookup C[k][c]; zero latency, no flow control.
module dct8_coef_rom
  import dct_pkg::*;
(
  input  logic [2:0]           k,
  input  logic [2:0]           c,
  output logic signed [CW-1:0] coef
);

  assign coef = dct8_coef(k, c);

endmodule

// File: rtl/dct8_serial_fwd.sv
// Serial 8-point forward DCT: loads 8 samples, then one MAC per cycle per coefficient.
// First y[k] valid 8 cycles after the 8th sample; each y[k] is held until out_ready.
module dct8_serial_fwd
  import dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [DW-1:0]   d_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   add,
  input  logic [SH_W-1:0]        shift,
  output logic signed [DW-1:0]   d_out,
  output logic [2:0]             out_index,
  output logic                   out_valid,
  input  logic                   out_ready
);

  dct_state_t              state, state_nxt;
  logic [2:0]              n, k, c;
  logic signed [DW-1:0]    xbuf [8];
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]    add_cap;
  logic [SH_W-1:0]         shift_cap;

  logic                    in_fire, out_fire;
  logic signed [CW-1:0]    coef;
  logic signed [DW-1:0]    x_sel;
  logic signed [ACC_W-1:0] x_ext, c_ext, a_ext, prod, mac, sum, shifted;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  dct8_coef_rom u_rom (
    .k    (k),
    .c    (c),
    .coef (coef)
  );

  // Operands are widened before the multiply so the product and sums stay in 37 bits.
  assign x_sel   = xbuf[c];
  assign x_ext   = {{(ACC_W-DW){x_sel[DW-1]}}, x_sel};
  assign c_ext   = {{(ACC_W-CW){coef[CW-1]}}, coef};
  assign a_ext   = {{(ACC_W-DW){add_cap[DW-1]}}, add_cap};
  assign prod    = x_ext * c_ext;
  assign mac     = acc + prod;
  assign sum     = mac + a_ext;
  assign shifted = sum >>> shift_cap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (in_fire && n == 3'd7) state_nxt = CALC;
      CALC: if (c == 3'd7) state_nxt = OUT;
      OUT:  if (out_fire) state_nxt = (k == 3'd7) ? LOAD : CALC;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n         <= '0;
      k         <= '0;
      c         <= '0;
      acc       <= '0;
      add_cap   <= '0;
      shift_cap <= '0;
      d_out     <= '0;
      out_index <= '0;
      for (int i = 0; i < 8; i++) xbuf[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            xbuf[n] <= d_in;
            n       <= n + 3'd1;
            if (n == 3'd0) begin
              add_cap   <= add;
              shift_cap <= shift;
            end
            if (n == 3'd7) begin
              k   <= '0;
              c   <= '0;
              acc <= '0;
            end
          end
        end
        CALC: begin
          if (c == 3'd7) begin
            d_out     <= shifted[DW-1:0];
            out_index <= k;
            c         <= '0;
          end else begin
            acc <= mac;
            c   <= c + 3'd1;
          end
        end
        OUT: begin
          if (out_fire) begin
            acc <= '0;
            k   <= k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dct8_serial_fwd.sv
// Directed bench for dct8_serial_fwd: fixed rows with hand-computed coefficients,
// output stalls, input gaps, latency/row-period timing and mid-row reset.
module tb_dct8_serial_fwd;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [24:0] d_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [24:0] add;
  logic [3:0]         shift;
  logic signed [24:0] d_out;
  logic [2:0]         out_index;
  logic               out_valid;
  logic               out_ready;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int t_first, t_last, lat0;
  int xv [8];
  int ey [8];

  dct8_serial_fwd dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add       (add),
    .shift     (shift),
    .d_out     (d_out),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [39:0] act, input logic signed [39:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds xv[0..7]; add/shift are scrambled after x[0] to show they were captured.
  task automatic send_row(input bit gaps, input int a, input int s);
    int  i = 0;
    int  budget = 0;
    bit  fire;
    add   = 25'(a);
    shift = 4'(s);
    while (i < 8 && budget < 200) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        d_in     = 25'($urandom);
      end else begin
        in_valid = 1'b1;
        d_in     = 25'(xv[i]);
      end
      fire = in_valid && in_ready;
      step();
      budget++;
      if (fire) begin
        if (i == 0) t_first = cyc;
        if (i == 0) begin
          add   = 25'($urandom);
          shift = 4'($urandom);
        end
        i++;
      end
    end
    if (i < 8) check("send_timeout", i, 8);
    in_valid = 1'b1;
    d_in     = 25'h0abcde;
  endtask

  // Collects nk coefficients against ey; stall_k gets out_ready low for 5 cycles.
  task automatic recv_row(input string rn, input int nk, input int stall_k);
    int cnt;
    logic signed [24:0] held;
    for (int kk = 0; kk < nk; kk++) begin
      cnt = 0;
      while (!out_valid && cnt < 40) begin
        step();
        cnt++;
      end
      if (!out_valid) begin
        check($sformatf("%s_timeout_y%0d", rn, kk), 0, 1);
        in_valid = 1'b0;
        return;
      end
      if (kk == 0) lat0 = cnt;
      check($sformatf("%s_y%0d", rn, kk), d_out, ey[kk]);
      check($sformatf("%s_idx%0d", rn, kk), out_index, kk);
      check($sformatf("%s_inrdy%0d", rn, kk), in_ready, 0);
      if (kk == stall_k) begin
        held = d_out;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          check($sformatf("%s_stall_vld%0d", rn, s), out_valid, 1);
          check($sformatf("%s_stall_dat%0d", rn, s), d_out, held);
          check($sformatf("%s_stall_idx%0d", rn, s), out_index, kk);
          check($sformatf("%s_stall_inrdy%0d", rn, s), in_ready, 0);
        end
        out_ready = 1'b1;
      end
      if (kk == 7) in_valid = 1'b0;
      step();
      if (kk == 7) t_last = cyc;
      check($sformatf("%s_vld_drop%0d", rn, kk), out_valid, 0);
      if (kk == 7) check($sformatf("%s_inrdy_end", rn), in_ready, 1);
    end
  endtask

  task automatic fill(input int x0, input int xr);
    xv[0] = x0;
    for (int i = 1; i < 8; i++) xv[i] = xr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; d_in = '0; in_valid = 1'b0; add = '0; shift = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_d_out", d_out, 0);
    check("rst_out_index", out_index, 0);
    #10 reset = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); step();

    // All ones: DC only; also first-coefficient latency and row period.
    fill(1, 1);
    ey = '{512, 0, 0, 0, 0, 0, 0, 0};
    send_row(1'b0, 0, 0);
    recv_row("ones", 8, -1);
    check("latency", lat0, 8);
    check("row_period", t_last - t_first, 79);

    // Impulse, with a 5-cycle stall on y[3].
    fill(1, 0);
    ey = '{64, 89, 83, 75, 64, 50, 36, 18};
    send_row(1'b0, 0, 0);
    recv_row("imp", 8, 3);

    // Negative impulse with rounding: arithmetic shift of negatives.
    fill(-1, 0);
    ey = '{0, -1, -1, -1, 0, 0, 0, 0};
    send_row(1'b0, 64, 7);
    recv_row("neg", 8, -1);

    // Constant 10 with random input gaps.
    fill(10, 10);
    ey = '{40, 0, 0, 0, 0, 0, 0, 0};
    send_row(1'b1, 64, 7);
    recv_row("tens", 8, -1);

    // Most negative inputs: DC sum is -2^33, needs the wide accumulator.
    fill(-16777216, -16777216);
    ey = '{-262144, 0, 0, 0, 0, 0, 0, 0};
    send_row(1'b0, 0, 15);
    recv_row("bigneg", 8, -1);

    // Reset during CALC of k=4.
    fill(1, 0);
    ey = '{64, 89, 83, 75, 64, 50, 36, 18};
    send_row(1'b0, 0, 0);
    recv_row("pre_rst", 4, -1);
    step(); step();
    check("calc_hold_d_out", d_out, 75);
    check("calc_out_valid", out_valid, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_d_out", d_out, 0);
    check("midrst_out_index", out_index, 0);
    @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    fill(1, 1);
    ey = '{512, 0, 0, 0, 0, 0, 0, 0};
    send_row(1'b0, 0, 0);
    recv_row("post_rst", 8, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
